regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised integer register file with two write ports, write-to-read bypass and a
//   per-register busy scoreboard. Decode marks a destination busy at issue; the ALU or
//   load writeback clears it. rsX_busy drives the hazard/stall logic; flush drops all
//   pending marks on a pipeline redirect.
// PARAMETERS
//   XLEN     32  data width per register
//   NREGS    32  register count; power of 2, >= 2; AW = $clog2(NREGS) (localparam)
//   ZERO_REG 1   1: register 0 reads 0, ignores writes, never busy; 0: ordinary register
//   BYPASS   1   1: same-cycle write data forwarded to reads; 0: reads return stored value
// PORTS
//   clk         in   1        clock, rising edge
//   rst_n       in   1        asynchronous, active-low reset
//   rs1_addr    in   AW       read port 1 address
//   rs2_addr    in   AW       read port 2 address
//   rs1_data    out  XLEN     read port 1 data (combinational)
//   rs2_data    out  XLEN     read port 2 data (combinational)
//   rs1_busy    out  1        rs1 has a pending, not yet forwardable write
//   rs2_busy    out  1        rs2 has a pending, not yet forwardable write
//   issue_valid in   1        request to mark issue_rd busy
//   issue_rd    in   AW       destination register being issued
//   issue_ready out  1        issue accepted this cycle (combinational)
//   wa_en       in   1        write port A (ALU writeback) enable
//   wa_addr     in   AW       write port A address
//   wa_data     in   XLEN     write port A data
//   wb_en       in   1        write port B (load writeback) enable
//   wb_addr     in   AW       write port B address
//   wb_data     in   XLEN     write port B data
//   flush       in   1        clear all busy bits
//   busy_count  out  AW+1     registered count of busy registers
// BEHAVIOUR
//   - Reset (async, any time incl. mid-operation): all registers 0, all busy bits 0,
//     busy_count 0; an issue or write in that cycle is lost. Read outputs follow
//     combinationally (0).
//   - Write: on posedge, mem[addr] <= data for each enabled port; the same edge clears
//     busy[addr]. A and B to the same addr in one cycle: B's data wins; busy cleared once.
//   - ZERO_REG=1: writes/issues to addr 0 are no-ops (issue_ready=1); reads of 0 return 0,
//     busy 0.
//   - Read: rsX_data = mem[rsX_addr]. BYPASS=1: if wb_en && wb_addr==rsX_addr return
//     wb_data, else if wa_en && wa_addr==rsX_addr return wa_data (zero-reg rule first).
//   - rsX_busy = busy[rsX_addr] & ~(BYPASS && matching enabled write this cycle).
//     BYPASS=0: rsX_busy = busy[rsX_addr] exactly, even when a write clears it this edge.
//   - issue_ready = ~busy[issue_rd] (WAW stall) | (ZERO_REG && issue_rd==0) | flush;
//     fire = issue_valid & issue_ready & ~flush; fire sets busy[issue_rd] at the edge.
//   - Same edge set and clear on one addr (fire + write to issue_rd): set wins, reg busy.
//   - flush: all busy bits 0 at the edge; a same-cycle issue is discarded; writes still
//     update data.
//   - busy_count <= popcount(next busy vector); range 0..NREGS(-1 if ZERO_REG);
//     never wraps.
//   - No latency beyond one edge: write visible to stored reads next cycle, bypass
//     immediate.
// TESTING
//   1. Reset, read all regs -> every rsX_data 0, rsX_busy 0, busy_count 0.
//   2. wa_en, addr 5, 0xDEADBEEF with rs1_addr=5 -> rs1_data 0xDEADBEEF same cycle
//      (BYPASS=1); next cycle from storage.
//   3. wa 7=0x11 and wb 7=0x22 same cycle -> reg 7 = 0x22; addr 0 write 0xFF -> reads 0.
//   4. Issue rd 3 -> busy_count 1, rs2_busy(3)=1; re-issue 3 -> issue_ready 0;
//      wb 3=0x44 -> rs2_busy 0 that cycle, busy_count 0 next.
//   5. Issue 1,2,4 then flush+issue 6 together -> busy_count 0, reg 6 not busy,
//      contents unchanged.
//   6. Issue 9, pulse rst_n low mid-cycle -> outputs 0 immediately; reg 9 not busy
//      after release.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file: two write ports (A = ALU, B = load), write-to-read
// bypass, and a per-register busy scoreboard with issue/flush control.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(NREGS)-1:0] rs1_addr,
   input  logic [$clog2(NREGS)-1:0] rs2_addr,
   output logic [XLEN-1:0]          rs1_data,
   output logic [XLEN-1:0]          rs2_data,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   input  logic                     issue_valid,
   input  logic [$clog2(NREGS)-1:0] issue_rd,
   output logic                     issue_ready,
   input  logic                     wa_en,
   input  logic [$clog2(NREGS)-1:0] wa_addr,
   input  logic [XLEN-1:0]          wa_data,
   input  logic                     wb_en,
   input  logic [$clog2(NREGS)-1:0] wb_addr,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     flush,
   output logic [$clog2(NREGS):0]   busy_count
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic [AW:0]      count_next;
   logic             wa_ok;
   logic             wb_ok;
   logic             fire;

   // Writes to the hardwired zero register are dropped entirely.
   assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
   assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

   assign issue_ready = ~busy[issue_rd] | ((ZERO_REG != 0) && (issue_rd == '0)) | flush;
   assign fire        = issue_valid & issue_ready & ~flush;

   // Register storage; port B is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
      end else begin
         if (wa_ok) mem[wa_addr] <= wa_data;
         if (wb_ok) mem[wb_addr] <= wb_data;
      end
   end

   // Next busy vector: writeback clears, flush clears all, issue sets (set beats clear).
   always_comb begin
      busy_next = busy;
      if (wa_en) busy_next[wa_addr] = 1'b0;
      if (wb_en) busy_next[wb_addr] = 1'b0;
      if (flush) busy_next = '0;
      if (fire)  busy_next[issue_rd] = 1'b1;
      if (ZERO_REG != 0) busy_next[0] = 1'b0;
   end

   // Population count of the next busy vector so busy_count tracks it exactly.
   always_comb begin
      count_next = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         count_next = count_next + (AW+1)'(busy_next[i]);
      end
   end

   // Scoreboard state and its registered population count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_next;
         busy_count <= count_next;
      end
   end

   // Read port 1: stored value, optional forwarding (B over A), zero-register override.
   always_comb begin
      rs1_data = mem[rs1_addr];
      rs1_busy = busy[rs1_addr];
      if (BYPASS != 0) begin
         if (wb_en && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
         end else if (wa_en && (wa_addr == rs1_addr)) begin
            rs1_data = wa_data;
            rs1_busy = 1'b0;
         end
      end
      if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
         rs1_data = '0;
         rs1_busy = 1'b0;
      end
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      rs2_data = mem[rs2_addr];
      rs2_busy = busy[rs2_addr];
      if (BYPASS != 0) begin
         if (wb_en && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
         end else if (wa_en && (wa_addr == rs2_addr)) begin
            rs2_data = wa_data;
            rs2_busy = 1'b0;
         end
      end
      if ((ZERO_REG != 0) && (rs2_addr == '0)) begin
         rs2_data = '0;
         rs2_busy = 1'b0;
      end
   end

endmodule
